// File: rtl/sr_button_ctrl.sv
// Button front-end for SRCounter: synchronizes and debounces the start/stop and
// clear buttons, then turns debounced presses into registered run-control pulses.
module sr_button_ctrl #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned DB_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_clr,
    output logic       start,
    output logic       stop,
    output logic       clr,
    output logic       running,
    output logic [1:0] state
);

    // state   | meaning
    // IDLE    | counter stopped and cleared (or never started)
    // RUNNING | counter counting
    // PAUSED  | counter stopped, value held
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_t;

    localparam int BTN_SS  = 0;
    localparam int BTN_CLR = 1;

    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      level_q, level_d;
    logic [1:0]      prev_q;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic [1:0]      press;

    state_t state_q, state_d;
    logic   start_q, start_d;
    logic   stop_q, stop_d;
    logic   clr_q, clr_d;
    logic   running_q, running_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= {btn_clr, btn_ss};
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    // Level flips on the edge where the run of disagreeing samples reaches DB_CYCLES.
    always_comb begin
        level_d = level_q;
        cnt_d   = '{default: '0};
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = level_q & ~prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            clr_q     <= clr_d;
            running_q <= running_d;
        end
    end

    // Clear takes priority; a coincident start/stop press is dropped.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press[BTN_CLR]) begin
                    clr_d = 1'b1;
                end else if (press[BTN_SS]) begin
                    state_d = RUNNING;
                    start_d = 1'b1;
                end
            end
            RUNNING: begin
                if (press[BTN_CLR]) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    stop_d  = 1'b1;
                end else if (press[BTN_SS]) begin
                    state_d = PAUSED;
                    stop_d  = 1'b1;
                end
            end
            PAUSED: begin
                if (press[BTN_CLR]) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end else if (press[BTN_SS]) begin
                    state_d = RUNNING;
                    start_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUNNING);
    end

    assign start   = start_q;
    assign stop    = stop_q;
    assign clr     = clr_q;
    assign running = running_q;
    assign state   = state_q;

endmodule
